// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer: two requesters share one single-port data memory.
// Each grant runs IDLE -> ACCESS -> ACK (ack 2 cycles after grant); DMEM_ARB_ALIGN_CHK_EN enables misalignment errors.
module dmem_arbiter #(
    parameter int DW = 64,
    parameter int AW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          err0,
    output logic          err1,
    output logic          busy,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          win;
    logic [AW-1:0] win_addr;
    logic          access_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // With both requesting, prio picks; a lone requester always wins.
    assign win      = (req0 && req1) ? prio_q : req1;
    assign win_addr = win ? addr1 : addr0;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    id_d    = win;
                    we_d    = win ? we1 : we0;
                    addr_d  = win_addr;
                    wdata_d = win ? wdata1 : wdata0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                    err_d   = (win_addr[2:0] != 3'd0);
`else
                    err_d   = 1'b0;
`endif
                    prio_d  = ~win;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rdata_d = mem_read ? mem_rdata : '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes come straight off state so an async reset drops them immediately.
    assign access_en = (state_q == S_ACCESS) && !err_q;
    assign mem_read  = access_en && !we_q;
    assign mem_write = access_en && we_q;
    assign mem_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state_q == S_ACCESS) ? wdata_q : '0;
    assign busy      = (state_q != S_IDLE);

    assign ack0   = (state_q == S_ACK) && !id_q;
    assign ack1   = (state_q == S_ACK) && id_q;
    assign rdata0 = ack0 ? rdata_q : '0;
    assign rdata1 = ack1 ? rdata_q : '0;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign err0 = ack0 && err_q;
    assign err1 = ack1 && err_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter: a word-array memory model, per-port expected-response queues,
// and a monitor checking data, error flags, ack spacing and round-robin fairness.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [63:0] addr [2];
    logic [63:0] wdata [2];
    logic        ack0, ack1, err0, err1, busy, mem_read, mem_write;
    logic [63:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.DW(64), .AW(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory: 32 words, byte address divided by 8, combinational read.
    logic [63:0] mem    [32];
    logic [63:0] shadow [32];
    assign mem_rdata = mem[mem_addr[7:3]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q0[$];
    resp_t exp_q1[$];
    int    ack_port[$];
    int    ack_cyc[$];
    int    last_ack = -100;
    int    wait_cnt [2];

    // Reference: each access behaves as an atomic operation on the shadow memory.
    function automatic void expect_access(int p, logic w, logic [63:0] a, logic [63:0] d);
        resp_t r;
        if (CHK_ON && a[2:0] != 3'd0) begin
            r.err = 1'b1; r.rdata = '0;
        end else begin
            r.err = 1'b0;
            if (w) begin
                shadow[a[7:3]] = d; r.rdata = '0;
            end else begin
                r.rdata = shadow[a[7:3]];
            end
        end
        if (p == 0) exp_q0.push_back(r);
        else        exp_q1.push_back(r);
    endfunction

    task automatic mon_port(int p, logic a, logic [63:0] rd, logic er, logic other_req);
        resp_t r;
        if (a) begin
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                checks++; errors++;
                $display("FAIL unexpected_ack port %0d: got ack expected none", p);
            end else begin
                r = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("rdata%0d", p), rd, r.rdata);
                chk($sformatf("err%0d", p), {63'd0, er}, {63'd0, r.err});
            end
            if (last_ack >= 0) chk("ack_spacing_ge3", {63'd0, (cyc - last_ack) >= 3}, 64'd1);
            last_ack = cyc;
            ack_port.push_back(p);
            ack_cyc.push_back(cyc);
            wait_cnt[p] = 0;
            if (other_req) begin
                wait_cnt[1-p]++;
                chk("fairness_within_2", {63'd0, wait_cnt[1-p] <= 1}, 64'd1);
            end
        end else begin
            chk($sformatf("rdata%0d_idle_zero", p), rd, 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mem_rw_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
            mon_port(0, ack0, rdata0, err0, req[1]);
            mon_port(1, ack1, rdata1, err1, req[0]);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; we = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack", {62'd0, ack1, ack0}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_mem_rw", {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_rdata", rdata0 | rdata1, 64'd0);
        last_ack = -100;
        wait_cnt[0] = 0; wait_cnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(int p, logic w, logic [63:0] a, logic [63:0] d);
        @(negedge clk);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
        expect_access(p, w, a, d);
    endtask

    task automatic wait_ack(int p, output int nwr);
        bit done = 1'b0;
        nwr = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk); #1;
            if (mem_write) nwr++;
            if ((p == 0) ? ack0 : ack1) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout port %0d: got no ack expected ack within 40 cycles", p);
        end
        req[p] = 1'b0;
    endtask

    task automatic run_access(int p, logic w, logic [63:0] a, logic [63:0] d);
        int nwr;
        issue(p, w, a, d);
        wait_ack(p, nwr);
    endtask

    task automatic driver(int p, int n);
        for (int k = 0; k < n; k++) begin
            logic [63:0] a, d;
            int word, low;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            word = p * 8 + int'($urandom_range(0, 7));
            low  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            a = 64'(word * 8 + low);
            d = {$urandom, $urandom};
            run_access(p, 1'($urandom_range(0, 1)), a, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nwr;
        logic [63:0] old1;
        for (int i = 0; i < 32; i++) begin
            mem[i] = {$urandom, $urandom};
            shadow[i] = mem[i];
        end
        do_reset();

        // Write then read back, with exact timing of the write strobe and ack.
        issue(0, 1'b1, 64'h10, 64'hDEAD);
        @(negedge clk); #1;
        chk("t1_write_at_T1", {63'd0, mem_write}, 64'd1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_mem_addr", mem_addr, 64'h10);
        chk("t1_mem_wdata", mem_wdata, 64'hDEAD);
        @(negedge clk); #1;
        chk("t1_write_one_cycle", {63'd0, mem_write}, 64'd0);
        chk("t1_ack_at_T2", {63'd0, ack0}, 64'd1);
        req[0] = 1'b0;
        run_access(0, 1'b0, 64'h10, 64'h0);

        // Both held from reset: strict alternation, 3 cycles apart.
        do_reset();
        base = ack_port.size();
        @(negedge clk);
        req = 2'b11; we = 2'b00; addr[0] = 64'h0; addr[1] = 64'h8;
        for (int k = 0; k < 2; k++) begin
            expect_access(0, 1'b0, 64'h0, 64'h0);
            expect_access(1, 1'b0, 64'h8, 64'h0);
        end
        for (int i = 0; i < 30 && ack_port.size() < base + 4; i++) begin
            @(negedge clk); #1;
        end
        req = 2'b00;
        if (ack_port.size() < base + 4) begin
            checks++; errors++;
            $display("FAIL t2_ack_count: got %0d expected 4", ack_port.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) chk("t2_order", 64'(ack_port[base + i]), 64'(i % 2));
            for (int i = 1; i < 4; i++)
                chk("t2_spacing", 64'(ack_cyc[base + i] - ack_cyc[base + i - 1]), 64'd3);
        end

        // Lone req1 with prio=0 wins immediately; the next tie goes to port 0.
        do_reset();
        issue(1, 1'b0, 64'h40, 64'h0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("t3_req1_immediate", {63'd0, ack1}, 64'd1);
        req[1] = 1'b0;
        base = ack_port.size();
        fork
            run_access(0, 1'b0, 64'h0, 64'h0);
            run_access(1, 1'b0, 64'h48, 64'h0);
        join
        chk("t3_tie_to_port0", 64'(ack_port[base]), 64'd0);

        // Reset during the ACCESS of a write: strobe drops, memory untouched.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 64'h18; wdata[0] = 64'h55;
        @(negedge clk); #1;
        chk("t4_in_access", {63'd0, mem_write}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_write_abort", {63'd0, mem_write}, 64'd0);
        chk("t4_no_ack", {62'd0, ack1, ack0}, 64'd0);
        do_reset();
        run_access(0, 1'b0, 64'h18, 64'h0);

        // Address changing after grant has no effect.
        issue(0, 1'b0, 64'h8, 64'h0);
        @(negedge clk); #1;
        addr[0] = 64'h20;
        #1;
        chk("t5_latched_addr", mem_addr, 64'h8);
        wait_ack(0, nwr);

        // Misaligned write.
        old1 = mem[1];
        issue(0, 1'b1, 64'h0C, 64'h1234_5678);
        wait_ack(0, nwr);
        chk("t6_write_strobes", 64'(nwr), CHK_ON ? 64'd0 : 64'd1);
        chk("t6_word1", mem[1], CHK_ON ? old1 : 64'h1234_5678);

        // Random concurrent traffic on disjoint regions.
        fork
            driver(0, 40);
            driver(1, 40);
        join
        repeat (4) @(negedge clk);
        chk("leftover_q0", 64'(exp_q0.size()), 64'd0);
        chk("leftover_q1", 64'(exp_q1.size()), 64'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], shadow[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
